// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   Oversampling UART receiver. Frame format (data length, parity enable and
//   type, number of stop bits) is captured at the start-bit centre and held
//   for the whole frame. Data bits arrive LSB first.
//
//   Optional feature macro: UART_RX_SYNC_EN
//     When defined, i_rx_serial passes through a 2-flop synchronizer
//     (reset value 1) before the FSM.
//
// Ports
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   rx_tick         one-clk enable pulse at OVERSAMPLE x baud
//   i_num_bit_data  data length: 00=5, 01=6, 10=7, 11=8 bits
//   i_stop_bit      0 = one stop bit, 1 = two stop bits
//   i_parity_en     1 = a parity bit follows the data bits
//   i_parity_type   0 = even, 1 = odd
//   i_rx_serial     serial line, idle high
//   o_data          received word, LSB aligned, unused upper bits 0
//   o_rx_done       one-clk pulse when a frame completes
//   o_parity_err    parity mismatch flag of the last frame
//   state_dbg       current FSM state (0=IDLE 1=START 2=DATA 3=PARITY 4=STOP)
//
// Output handshake: o_rx_done is a single-cycle valid strobe with no ready;
// o_data and o_parity_err are valid in that cycle and held until the next
// frame completes.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_tick,
  input  logic [1:0] i_num_bit_data,
  input  logic       i_stop_bit,
  input  logic       i_parity_en,
  input  logic       i_parity_type,
  input  logic       i_rx_serial,
  output logic [7:0] o_data,
  output logic       o_rx_done,
  output logic       o_parity_err,
  output logic [2:0] state_dbg
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t state, state_next;

  // Serial input, optionally synchronized
  logic rx_s;
`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], i_rx_serial};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = i_rx_serial;
`endif

  // Datapath registers
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          par_bit_q;
  logic          second_stop_q;
  logic [1:0]    nbits_q;
  logic          stop2_q;
  logic          par_en_q;
  logic          par_type_q;

  // Control strobes from the FSM
  logic cnt_clr, cnt_inc, latch_cfg, sample_data, sample_par;
  logic set_second_stop, frame_done;

  // Index of the last data bit: 4..7 for 5..8 bits
  logic [2:0] last_idx;
  assign last_idx = 3'd4 + {1'b0, nbits_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next      = state;
    cnt_clr         = 1'b0;
    cnt_inc         = 1'b0;
    latch_cfg       = 1'b0;
    sample_data     = 1'b0;
    sample_par      = 1'b0;
    set_second_stop = 1'b0;
    frame_done      = 1'b0;
    if (rx_tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_next = START;
            cnt_clr    = 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt_clr = 1'b1;
            // A line back high at mid start bit is a glitch, not a frame
            if (!rx_s) begin
              state_next = DATA;
              latch_cfg  = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt_clr     = 1'b1;
            sample_data = 1'b1;
            if (bit_idx == last_idx) state_next = par_en_q ? PARITY : STOP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        PARITY: begin
          if (cnt == LAST) begin
            cnt_clr    = 1'b1;
            sample_par = 1'b1;
            state_next = STOP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        STOP: begin
          // Stop-bit value is not checked; the frame is delivered regardless
          if (cnt == LAST) begin
            cnt_clr = 1'b1;
            if (stop2_q && !second_stop_q) begin
              set_second_stop = 1'b1;
            end else begin
              frame_done = 1'b1;
              state_next = IDLE;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      bit_idx       <= '0;
      shift_q       <= '0;
      par_bit_q     <= 1'b0;
      second_stop_q <= 1'b0;
      nbits_q       <= '0;
      stop2_q       <= 1'b0;
      par_en_q      <= 1'b0;
      par_type_q    <= 1'b0;
      o_data        <= '0;
      o_rx_done     <= 1'b0;
      o_parity_err  <= 1'b0;
    end else begin
      o_rx_done <= frame_done;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (latch_cfg) begin
        nbits_q       <= i_num_bit_data;
        stop2_q       <= i_stop_bit;
        par_en_q      <= i_parity_en;
        par_type_q    <= i_parity_type;
        bit_idx       <= '0;
        shift_q       <= '0;
        par_bit_q     <= 1'b0;
        second_stop_q <= 1'b0;
      end
      // Bits land directly at their final position, so short words come out
      // LSB aligned with zero upper bits
      if (sample_data) begin
        shift_q[bit_idx] <= rx_s;
        bit_idx          <= bit_idx + 3'd1;
      end
      if (sample_par)      par_bit_q     <= rx_s;
      if (set_second_stop) second_stop_q <= 1'b1;
      if (frame_done) begin
        o_data       <= shift_q;
        o_parity_err <= par_en_q & ((^shift_q) ^ par_bit_q ^ par_type_q);
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Directed frames with hand-computed expected words. Expected responses are
//   queued when a frame is sent; a monitor pops them on every o_rx_done.
//   rx_tick runs every TICK_DIV clocks to keep the run short; one bit period
//   is 16 * TICK_DIV clocks.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  logic       clk;
  logic       rst_n;
  logic       rx_tick;
  logic [1:0] i_num_bit_data;
  logic       i_stop_bit;
  logic       i_parity_en;
  logic       i_parity_type;
  logic       i_rx_serial;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_parity_err;
  logic [2:0] state_dbg;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_tick        (rx_tick),
    .i_num_bit_data (i_num_bit_data),
    .i_stop_bit     (i_stop_bit),
    .i_parity_en    (i_parity_en),
    .i_parity_type  (i_parity_type),
    .i_rx_serial    (i_rx_serial),
    .o_data         (o_data),
    .o_rx_done      (o_rx_done),
    .o_parity_err   (o_parity_err),
    .state_dbg      (state_dbg)
  );

  // Clock and tick generation
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int tick_cnt = 0;
  always @(posedge clk) begin
    if (tick_cnt == TICK_DIV - 1) begin
      tick_cnt <= 0;
      rx_tick  <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1;
      rx_tick  <= 1'b0;
    end
  end

  // Scoreboard: {parity_err, data}
  logic [8:0] exp_q[$];
  int checks     = 0;
  int errors     = 0;
  int done_cnt   = 0;
  int exp_frames = 0;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor
  logic [8:0] mon_exp;
  always @(negedge clk) begin
    if (rst_n && o_rx_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got data 0x%0h err %0b expected no frame", o_data, o_parity_err);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rx_data", {1'b0, o_data}, {1'b0, mon_exp[7:0]});
        check("rx_parity_err", {8'd0, o_parity_err}, {8'd0, mon_exp[8]});
      end
    end
  end

  // Driver tasks
  task automatic drive_bit(input logic b, input int clks);
    i_rx_serial = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic [1:0] nb,
                            input logic s2, input logic pe, input logic pt,
                            input logic pbit, input logic scramble, input int bclks,
                            input logic [7:0] exp_data, input logic exp_err);
    i_num_bit_data = nb;
    i_stop_bit     = s2;
    i_parity_en    = pe;
    i_parity_type  = pt;
    exp_q.push_back({exp_err, exp_data});
    exp_frames++;
    drive_bit(1'b0, bclks);
    if (scramble) begin
      i_num_bit_data = ~nb;
      i_stop_bit     = ~s2;
      i_parity_en    = ~pe;
      i_parity_type  = ~pt;
    end
    for (int i = 0; i < 5 + int'(nb); i++) drive_bit(data[i], bclks);
    if (pe) drive_bit(pbit, bclks);
    drive_bit(1'b1, bclks);
    if (s2) drive_bit(1'b1, bclks);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending frames expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rx_tick        = 1'b0;
    rst_n          = 1'b0;
    i_rx_serial    = 1'b1;
    i_num_bit_data = 2'b11;
    i_stop_bit     = 1'b0;
    i_parity_en    = 1'b0;
    i_parity_type  = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_data", {1'b0, o_data}, 9'h000);
    check("reset_done", {8'd0, o_rx_done}, 9'h000);
    check("reset_parity_err", {8'd0, o_parity_err}, 9'h000);
    check("reset_state", {6'd0, state_dbg}, 9'h000);
    rst_n = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("idle_after_reset", {6'd0, state_dbg}, 9'h000);

    // Back-to-back directed frames
    //          data   nb     s2 pe pt pbit scr bclks      exp   err
    send_frame(8'hA5, 2'b11, 0, 0, 0, 0, 0, BIT_CLKS, 8'hA5, 0); // 8N1
    send_frame(8'h3C, 2'b11, 0, 1, 0, 0, 0, BIT_CLKS, 8'h3C, 0); // 8E1, good parity
    send_frame(8'h15, 2'b00, 1, 1, 1, 0, 0, BIT_CLKS, 8'h15, 0); // 5O2, 3 ones -> pbit 0
    send_frame(8'h55, 2'b10, 0, 0, 0, 0, 0, BIT_CLKS, 8'h55, 0); // 7N1
    send_frame(8'hEB, 2'b01, 0, 0, 0, 0, 0, BIT_CLKS, 8'h2B, 0); // 6N1, upper bits dropped
    send_frame(8'hC3, 2'b11, 0, 0, 0, 0, 1, BIT_CLKS, 8'hC3, 0); // config changed mid-frame
    send_frame(8'h96, 2'b11, 0, 0, 0, 0, 0, BIT_CLKS + 1, 8'h96, 0); // slow sender
    send_frame(8'h69, 2'b11, 0, 0, 0, 0, 0, BIT_CLKS - 1, 8'h69, 0); // fast sender
    drain("b2b");

    // 3-tick low glitch on an idle line
    drive_bit(1'b0, 3 * TICK_DIV);
    drive_bit(1'b1, 3 * BIT_CLKS);
    check("glitch_state_idle", {6'd0, state_dbg}, 9'h000);
    check("glitch_no_frame", 9'(done_cnt), 9'(exp_frames));

    // 8E1 with inverted parity bit, leaves held outputs nonzero before reset
    send_frame(8'h3C, 2'b11, 0, 1, 0, 1, 0, BIT_CLKS, 8'h3C, 1);
    drive_bit(1'b1, BIT_CLKS);
    drain("bad_parity");
    check("held_data", {1'b0, o_data}, 9'h03C);

    // Reset in the middle of a 0xFF frame's data bits
    drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b1, 3 * BIT_CLKS + BIT_CLKS / 2);
    check("mid_frame_state_data", {6'd0, state_dbg}, 9'h002);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_data", {1'b0, o_data}, 9'h000);
    check("midrst_done", {8'd0, o_rx_done}, 9'h000);
    check("midrst_parity_err", {8'd0, o_parity_err}, 9'h000);
    check("midrst_state", {6'd0, state_dbg}, 9'h000);
    rst_n = 1'b1;
    drive_bit(1'b1, 6 * BIT_CLKS);
    check("after_abort_no_frame", 9'(done_cnt), 9'(exp_frames));
    send_frame(8'h5A, 2'b11, 0, 0, 0, 0, 0, BIT_CLKS, 8'h5A, 0);
    drive_bit(1'b1, BIT_CLKS);
    drain("after_reset");

    check("done_count", 9'(done_cnt), 9'(exp_frames));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning rx_tick pulses per serial bit period.
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port rx_tick, input, 1, oversample enable, one-clk pulse at OVERSAMPLE x baud.
REQ-005 SHALL have port i_num_bit_data, input, 2, data bits: 00=5, 01=6, 10=7, 11=8.
REQ-006 SHALL have port i_stop_bit, input, 1, 0=one stop bit, 1=two stop bits.
REQ-007 SHALL have port i_parity_en, input, 1, 1=parity bit follows the data bits.
REQ-008 SHALL have port i_parity_type, input, 1, 0=even, 1=odd.
REQ-009 SHALL have port i_rx_serial, input, 1, serial line, idle high.
REQ-010 SHALL have port o_data, output, 8, received word, LSB-aligned, unused upper bits 0.
REQ-011 SHALL have port o_rx_done, output, 1, one-clk pulse when a frame completes.
REQ-012 SHALL have port o_parity_err, output, 1, parity mismatch flag for the last frame.
REQ-013 SHALL use clock clk and reset rst_n, asynchronous, active-low.

Function
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; all sampling advances only on clk edges where rx_tick=1.
REQ-015 IDLE: the FSM SHALL move to START and clear the tick counter when the line is 0.
REQ-016 START: at tick count OVERSAMPLE/2-1 (7), line 0 SHALL give DATA with the counter cleared; line 1 SHALL give IDLE (glitch rejection).
REQ-017 START->DATA SHALL latch i_num_bit_data, i_stop_bit, i_parity_en and i_parity_type; these values are held for the whole frame.
REQ-018 DATA: each bit SHALL be sampled at tick count OVERSAMPLE-1 (15) and shifted in LSB first; after N bits the FSM goes to PARITY if parity is enabled, else STOP.
REQ-019 PARITY: the bit SHALL be sampled at count 15; error = (XOR of the N data bits XOR parity bit) XOR i_parity_type.
REQ-020 STOP: the first stop bit SHALL be sampled at count 15; if two stop bits are set, a second stop bit is sampled 16 ticks later.
REQ-021 At the end of STOP, in the same clk cycle, the block SHALL update o_data, update o_parity_err (0 if parity disabled), pulse o_rx_done for exactly one clk, and return to IDLE.
REQ-022 o_data SHALL be valid in the cycle o_rx_done=1 and held until the next frame completes.
REQ-023 A stop bit sampled as 0 SHALL NOT block completion: the frame is still delivered with o_rx_done; no frame-error output exists.
REQ-024 After a frame, IDLE SHALL accept a new start bit immediately; back-to-back frames are supported.
REQ-025 Configuration input changes during a frame SHALL NOT affect that frame.
REQ-026 Input timing tolerance: correct reception SHALL be guaranteed for baud mismatch of at most +/-2%.

Reset
REQ-027 On rst_n=0 the FSM SHALL enter IDLE, clear counters and the shift register, and drive o_data=0, o_rx_done=0, o_parity_err=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no o_rx_done.
REQ-029 After reset release the block SHALL wait for the line to go low before starting a frame.

Configuration
REQ-030 With macro UART_RX_SYNC_EN defined, i_rx_serial SHALL pass through a 2-flop synchronizer (reset value 1) before the FSM, adding 2 clk latency.
REQ-031 Without UART_RX_SYNC_EN, the FSM SHALL sample i_rx_serial directly.

Verification
REQ-032 50 MHz clk, rx_tick every 326 clks, bit period 104167 ns; send 8N1 0xA5 -> single o_rx_done with o_data=0xA5 and o_parity_err=0.
REQ-033 8-bit, even parity, byte 0x3C with correct parity bit 0 -> o_data=0x3C, o_parity_err=0; repeat with the parity bit inverted -> o_parity_err=1.
REQ-034 5-bit, odd parity, two stop bits, data 0x15 -> o_data=0x15, o_parity_err=0, o_rx_done exactly once.
REQ-035 Low glitch of 3 ticks on an idle line -> no o_rx_done, FSM back in IDLE.
REQ-036 rst_n pulsed low mid-DATA of a 0xFF frame -> no o_rx_done, all outputs 0; the next 0x5A frame is received correctly.
